// File: rtl/memrq_arbiter.sv
// memrq_arbiter: merges an instruction-fetch client (read-only) and a data
// client (read/write) onto the single-outstanding memory request bridge and
// routes each bridge response back to the client that issued it.
// Optional feature: define MEMARB_ROUND_ROBIN_EN to break ties by granting
// the client that did not win last time. Without it, data always beats
// instruction fetch.
module memrq_arbiter #(
  parameter int ISSUE_GAP = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inst_request_enable,
  input  logic [31:0] inst_req_addr,
  output logic        inst_response_enable,
  output logic [31:0] inst_resp_data,
  input  logic        data_request_enable,
  input  logic        data_req_mode,
  input  logic [31:0] data_req_addr,
  input  logic [31:0] data_req_wdata,
  input  logic [3:0]  data_req_wstrb,
  output logic        data_response_enable,
  output logic [31:0] data_resp_data,
  output logic        request_enable,
  output logic        req_mode,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  input  logic        response_enable,
  input  logic [31:0] resp_data,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, GAP} state_t;
  typedef enum logic {INST = 1'b0, DATA = 1'b1} client_t;

`ifdef MEMARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  state_t      state, state_next;
  client_t     owner, last_grant;
  logic [3:0]  gap_cnt;

  logic        inst_valid;
  logic [31:0] inst_addr;
  logic        data_valid;
  logic        data_mode;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;

  logic        issue;
  logic        done;
  logic        grant_data;

  assign busy = (state != IDLE);

  // Winner selection: data unless only instruction is waiting; ties go to the
  // client that did not win last when round-robin is enabled.
  always_comb begin
    grant_data = data_valid;
    if (RR_EN && data_valid && inst_valid) grant_data = (last_grant == INST);
  end

  // Next-state logic plus the one-cycle issue/done strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next = state;
    issue      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (inst_valid || data_valid) begin
          issue      = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE:     state_next = WAIT_RESP;
      WAIT_RESP: begin
        if (response_enable) begin
          done       = 1'b1;
          state_next = (ISSUE_GAP == 0) ? IDLE : GAP;
        end
      end
      GAP:       if (gap_cnt <= 4'd1) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // State register and post-response gap counter.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rstn) begin
      state   <= IDLE;
      gap_cnt <= 4'd0;
    end else begin
      state <= state_next;
      if (done)              gap_cnt <= 4'(ISSUE_GAP);
      else if (state == GAP) gap_cnt <= gap_cnt - 4'd1;
    end
  end

  // Pending slots: a pulse on a free slot is captured; a pulse on an occupied
  // slot is dropped and latches overrun. Completion clear beats a same-edge pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: payload registers are reset as well even though valid qualifies
      // them; it keeps the whole block in a known state after reset.
      inst_valid <= 1'b0;
      inst_addr  <= '0;
      data_valid <= 1'b0;
      data_mode  <= 1'b0;
      data_addr  <= '0;
      data_wdata <= '0;
      data_wstrb <= '0;
      overrun    <= 1'b0;
    end else begin
      if ((inst_request_enable && inst_valid) || (data_request_enable && data_valid))
        overrun <= 1'b1;

      if (done && owner == INST) begin
        inst_valid <= 1'b0;
      end else if (inst_request_enable && !inst_valid) begin
        inst_valid <= 1'b1;
        inst_addr  <= inst_req_addr;
      end

      if (done && owner == DATA) begin
        data_valid <= 1'b0;
      end else if (data_request_enable && !data_valid) begin
        data_valid <= 1'b1;
        data_mode  <= data_req_mode;
        data_addr  <= data_req_addr;
        data_wdata <= data_req_wdata;
        data_wstrb <= data_req_wstrb;
      end
    end
  end

  // Downstream request: one-cycle pulse carrying the winner's fields.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      request_enable <= 1'b0;
      req_mode       <= 1'b0;
      req_addr       <= '0;
      req_wdata      <= '0;
      req_wstrb      <= '0;
      owner          <= INST;
    end else begin
      request_enable <= issue;
      if (issue) begin
        if (grant_data) begin
          owner     <= DATA;
          req_mode  <= data_mode;
          req_addr  <= data_addr;
          req_wdata <= data_wdata;
          req_wstrb <= data_wstrb;
        end else begin
          owner     <= INST;
          req_mode  <= 1'b0;
          req_addr  <= inst_addr;
          req_wdata <= '0;
          req_wstrb <= '0;
        end
      end
    end
  end

  // Response routing back to the owner; the other client's data holds.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inst_response_enable <= 1'b0;
      inst_resp_data       <= '0;
      data_response_enable <= 1'b0;
      data_resp_data       <= '0;
      last_grant           <= INST;
    end else begin
      inst_response_enable <= done && (owner == INST);
      data_response_enable <= done && (owner == DATA);
      if (done) begin
        last_grant <= owner;
        if (owner == INST) inst_resp_data <= resp_data;
        else               data_resp_data <= resp_data;
      end
    end
  end

endmodule

// File: tb/tb_memrq_arbiter.sv
// tb_memrq_arbiter: scoreboard bench. Stimulus pushes expected transactions
// into per-client queues; a negedge monitor (which also plays the bridge)
// decides from the arbitration rules which request must appear and which
// client must see each response, and compares against the DUT.
// A second instance with ISSUE_GAP=3 is used for the issue-gap timing.
`timescale 1ns/1ps
module tb_memrq_arbiter;

  localparam int GAP   = 0;
  localparam int GAP_G = 3;

  typedef struct {
    bit          is_data;
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] resp;
    int          cap;
  } item_t;

  typedef struct {
    bit          is_data;
    logic [31:0] addr;
  } grant_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        inst_request_enable = 1'b0;
  logic [31:0] inst_req_addr = '0;
  logic        inst_response_enable;
  logic [31:0] inst_resp_data;
  logic        data_request_enable = 1'b0;
  logic        data_req_mode = 1'b0;
  logic [31:0] data_req_addr = '0;
  logic [31:0] data_req_wdata = '0;
  logic [3:0]  data_req_wstrb = '0;
  logic        data_response_enable;
  logic [31:0] data_resp_data;
  logic        request_enable;
  logic        req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        response_enable = 1'b0;
  logic [31:0] resp_data = '0;
  logic        busy;
  logic        overrun;

  logic        g_inst_request_enable = 1'b0;
  logic [31:0] g_inst_req_addr = '0;
  logic        g_inst_response_enable;
  logic [31:0] g_inst_resp_data;
  logic        g_data_request_enable = 1'b0;
  logic [31:0] g_data_req_addr = '0;
  logic        g_data_response_enable;
  logic [31:0] g_data_resp_data;
  logic        g_request_enable;
  logic        g_req_mode;
  logic [31:0] g_req_addr;
  logic [31:0] g_req_wdata;
  logic [3:0]  g_req_wstrb;
  logic        g_response_enable = 1'b0;
  logic [31:0] g_resp_data = '0;
  logic        g_busy;
  logic        g_overrun;

  memrq_arbiter #(.ISSUE_GAP(GAP)) dut (
    .clk(clk), .rstn(rstn),
    .inst_request_enable(inst_request_enable), .inst_req_addr(inst_req_addr),
    .inst_response_enable(inst_response_enable), .inst_resp_data(inst_resp_data),
    .data_request_enable(data_request_enable), .data_req_mode(data_req_mode),
    .data_req_addr(data_req_addr), .data_req_wdata(data_req_wdata),
    .data_req_wstrb(data_req_wstrb),
    .data_response_enable(data_response_enable), .data_resp_data(data_resp_data),
    .request_enable(request_enable), .req_mode(req_mode), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .response_enable(response_enable), .resp_data(resp_data),
    .busy(busy), .overrun(overrun)
  );

  memrq_arbiter #(.ISSUE_GAP(GAP_G)) dut_g (
    .clk(clk), .rstn(rstn),
    .inst_request_enable(g_inst_request_enable), .inst_req_addr(g_inst_req_addr),
    .inst_response_enable(g_inst_response_enable), .inst_resp_data(g_inst_resp_data),
    .data_request_enable(g_data_request_enable), .data_req_mode(1'b0),
    .data_req_addr(g_data_req_addr), .data_req_wdata(32'h0), .data_req_wstrb(4'h0),
    .data_response_enable(g_data_response_enable), .data_resp_data(g_data_resp_data),
    .request_enable(g_request_enable), .req_mode(g_req_mode), .req_addr(g_req_addr),
    .req_wdata(g_req_wdata), .req_wstrb(g_req_wstrb),
    .response_enable(g_response_enable), .resp_data(g_resp_data),
    .busy(g_busy), .overrun(g_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] bridge_fn(input logic [31:0] a);
    return a ^ 32'hDEADBFEF;
  endfunction

  // Reference model state
  item_t       iq[$];
  item_t       dq[$];
  grant_t      issued[$];
  bit          outstanding = 0;
  bit          owner_data = 0;
  int          last_er = -100;
  int          er_edge = -1;
  int          bridge_cnt = 0;
  int          bridge_dly = 1;
  logic [31:0] cur_resp = '0;
  bit          m_overrun = 0;
  bit          m_last_data = 0;
  logic [31:0] m_inst_rdata = '0;
  logic [31:0] m_data_rdata = '0;
  int          inst_resp_cnt = 0;
  int          data_resp_cnt = 0;
  bit          spurious_en = 0;

  item_t mit;
  bit    resp_now, inst_ok, data_ok, exp_req, win_data;

  // Monitor + bridge model: runs on every falling edge.
  always @(negedge clk) begin
    if (!rstn) begin
      iq.delete();
      dq.delete();
      outstanding     = 0;
      bridge_cnt      = 0;
      er_edge         = -1;
      last_er         = -100;
      m_overrun       = 0;
      m_last_data     = 0;
      m_inst_rdata    = '0;
      m_data_rdata    = '0;
      response_enable = 1'b0;
    end else begin
      resp_now = (er_edge == cyc);
      check("inst_response_enable", 32'(inst_response_enable), 32'(resp_now && !owner_data));
      check("data_response_enable", 32'(data_response_enable), 32'(resp_now && owner_data));
      if (inst_response_enable) inst_resp_cnt++;
      if (data_response_enable) data_resp_cnt++;
      if (resp_now) begin
        if (owner_data && dq.size() > 0) begin
          mit = dq.pop_front();
          m_data_rdata = mit.resp;
        end else if (!owner_data && iq.size() > 0) begin
          mit = iq.pop_front();
          m_inst_rdata = mit.resp;
        end
        outstanding = 0;
        last_er     = cyc;
        m_last_data = owner_data;
      end
      check("inst_resp_data", inst_resp_data, m_inst_rdata);
      check("data_resp_data", data_resp_data, m_data_rdata);

      // bridge: respond after the programmed delay; noise on resp_data otherwise
      response_enable = 1'b0;
      resp_data       = $urandom;
      if (bridge_cnt > 0) begin
        bridge_cnt--;
        if (bridge_cnt == 0) begin
          response_enable = 1'b1;
          resp_data       = cur_resp;
          er_edge         = cyc + 1;
        end
      end

      // request: must appear exactly when idle, allowed by the gap, and
      // something was captured before this edge
      inst_ok = (iq.size() > 0) && (iq[0].cap < cyc);
      data_ok = (dq.size() > 0) && (dq[0].cap < cyc);
      exp_req = !outstanding && (inst_ok || data_ok) && (cyc >= last_er + 1 + GAP);
      check("request_enable", 32'(request_enable), 32'(exp_req));
      if (request_enable && exp_req) begin
        win_data = data_ok;
        if (inst_ok && data_ok) begin
`ifdef MEMARB_ROUND_ROBIN_EN
          win_data = !m_last_data;
`else
          win_data = 1'b1;
`endif
        end
        mit = win_data ? dq[0] : iq[0];
        check("req_mode", 32'(req_mode), 32'(mit.mode));
        check("req_addr", req_addr, mit.addr);
        check("req_wdata", req_wdata, mit.wdata);
        check("req_wstrb", 32'(req_wstrb), 32'(mit.wstrb));
        outstanding = 1;
        owner_data  = win_data;
        bridge_cnt  = (bridge_dly == 0) ? int'($urandom_range(1, 4)) : bridge_dly;
        cur_resp    = mit.resp;
        issued.push_back('{win_data, mit.addr});
      end
      check("busy", 32'(busy), 32'(outstanding || (cyc < last_er + GAP)));
      check("overrun", 32'(overrun), 32'(m_overrun));

      // stray responses outside WAIT_RESP must be ignored
      if (spurious_en && !outstanding && bridge_cnt == 0 && $urandom_range(0, 7) == 0)
        response_enable = 1'b1;
    end
  end

  // One client cycle: optional pulses, random noise on idle fields.
  task automatic step(input bit ip, input logic [31:0] ia, input bit dp, input logic dm,
                      input logic [31:0] da, input logic [31:0] dw, input logic [3:0] ds);
    item_t it;
    @(negedge clk);
    #1;
    inst_request_enable = ip;
    inst_req_addr       = ip ? ia : $urandom;
    data_request_enable = dp;
    data_req_mode       = dp ? dm : 1'($urandom);
    data_req_addr       = dp ? da : $urandom;
    data_req_wdata      = dp ? dw : $urandom;
    data_req_wstrb      = dp ? ds : 4'($urandom);
    if (ip) begin
      if (iq.size() != 0) m_overrun = 1;
      else begin
        it = '{1'b0, 1'b0, ia, 32'h0, 4'h0, bridge_fn(ia), cyc + 1};
        iq.push_back(it);
      end
    end
    if (dp) begin
      if (dq.size() != 0) m_overrun = 1;
      else begin
        it = '{1'b1, dm, da, dw, ds, bridge_fn(da), cyc + 1};
        dq.push_back(it);
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((iq.size() != 0 || dq.size() != 0 || outstanding) && n < budget) begin
      idle();
      n++;
    end
    checks++;
    if (iq.size() != 0 || dq.size() != 0 || outstanding) begin
      errors++;
      $display("FAIL %s: timeout after %0d cycles, pending inst=%0d data=%0d", name, n, iq.size(), dq.size());
    end
    idle();
    idle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_request_enable"}, 32'(request_enable), 32'h0);
    check({tag, "_req_mode"}, 32'(req_mode), 32'h0);
    check({tag, "_req_addr"}, req_addr, 32'h0);
    check({tag, "_req_wdata"}, req_wdata, 32'h0);
    check({tag, "_req_wstrb"}, 32'(req_wstrb), 32'h0);
    check({tag, "_inst_resp_en"}, 32'(inst_response_enable), 32'h0);
    check({tag, "_inst_resp_data"}, inst_resp_data, 32'h0);
    check({tag, "_data_resp_en"}, 32'(data_response_enable), 32'h0);
    check({tag, "_data_resp_data"}, data_resp_data, 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_overrun"}, 32'(overrun), 32'h0);
  endtask

  initial begin
    int ic0, dc0, n;

    // reset
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    #1 rstn = 1'b1;
    idle();

    // single instruction read, bridge answers 3 cycles after request
    bridge_dly = 3;
    issued.delete();
    ic0 = inst_resp_cnt;
    dc0 = data_resp_cnt;
    step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drain("t_inst_read", 50);
    check("t1_issued_n", 32'(issued.size()), 32'd1);
    check("t1_addr", issued.size() > 0 ? issued[0].addr : 32'hFFFFFFFF, 32'h100);
    check("t1_inst_resp_n", 32'(inst_resp_cnt - ic0), 32'd1);
    check("t1_data_resp_n", 32'(data_resp_cnt - dc0), 32'd0);
    check("t1_inst_resp_data", inst_resp_data, 32'hDEADBEEF);

    // data write
    bridge_dly = 2;
    issued.delete();
    dc0 = data_resp_cnt;
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h80000004, 32'h12345678, 4'b0011);
    drain("t_data_write", 50);
    check("t2_addr", issued.size() > 0 ? issued[0].addr : 32'hFFFFFFFF, 32'h80000004);
    check("t2_data_resp_n", 32'(data_resp_cnt - dc0), 32'd1);
    check("t2_data_resp_data", data_resp_data, bridge_fn(32'h80000004));

    // contention: data first
    issued.delete();
    step(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    drain("t_contention", 50);
    check("t3_first", issued.size() > 0 ? issued[0].addr : 32'hFFFFFFFF, 32'h20);
    check("t3_second", issued.size() > 1 ? issued[1].addr : 32'hFFFFFFFF, 32'h10);

    // both clients re-request as soon as served
    issued.delete();
    bridge_dly = 2;
    repeat (60) step(iq.size() == 0, $urandom, dq.size() == 0, 1'($urandom), $urandom, $urandom, 4'($urandom));
    drain("t_rerequest", 50);
`ifdef MEMARB_ROUND_ROBIN_EN
    check("rr_first_is_data", issued.size() > 0 ? 32'(issued[0].is_data) : 32'hFFFFFFFF, 32'd1);
    for (int k = 1; k < issued.size(); k++)
      check("rr_alternate", 32'(issued[k].is_data), 32'(!issued[k-1].is_data));
`endif

    // overrun: second inst pulse while the first is pending
    bridge_dly = 4;
    issued.delete();
    step(1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drain("t_overrun", 50);
    check("t5_issued_n", 32'(issued.size()), 32'd1);
    check("t5_addr", issued.size() > 0 ? issued[0].addr : 32'hFFFFFFFF, 32'h30);
    check("t5_overrun", 32'(overrun), 32'd1);

    // randomized traffic with stray bridge responses
    bridge_dly  = 0;
    spurious_en = 1;
    repeat (400) step(iq.size() == 0 && $urandom_range(0, 2) == 0, $urandom,
                      dq.size() == 0 && $urandom_range(0, 2) == 0, 1'($urandom),
                      $urandom, $urandom, 4'($urandom));
    drain("t_random", 200);
    spurious_en = 0;

    // issue gap on the ISSUE_GAP=3 instance
    @(negedge clk);
    #1;
    g_inst_request_enable = 1'b1;
    g_inst_req_addr       = 32'h10;
    g_data_request_enable = 1'b1;
    g_data_req_addr       = 32'h20;
    @(negedge clk);
    #1;
    g_inst_request_enable = 1'b0;
    g_data_request_enable = 1'b0;
    n = 0;
    while (!g_request_enable && n < 20) begin @(negedge clk); n++; end
    check("gap_first_addr", g_req_addr, 32'h20);
    repeat (2) @(negedge clk);
    g_response_enable = 1'b1;
    g_resp_data       = 32'h000000A1;
    @(negedge clk);
    g_response_enable = 1'b0;
    g_resp_data       = 32'h0;
    check("gap_data_resp_en", 32'(g_data_response_enable), 32'd1);
    n = 0;
    while (!g_request_enable && n < 20) begin n++; @(negedge clk); end
    check("gap_idle_cycles", 32'(n), 32'(1 + GAP_G));
    check("gap_second_addr", g_req_addr, 32'h10);
    repeat (2) @(negedge clk);
    g_response_enable = 1'b1;
    g_resp_data       = 32'h000000B2;
    @(negedge clk);
    g_response_enable = 1'b0;
    check("gap_inst_resp_en", 32'(g_inst_response_enable), 32'd1);
    check("gap_inst_resp_data", g_inst_resp_data, 32'h000000B2);
    check("gap_data_hold", g_data_resp_data, 32'h000000A1);

    // reset in the middle of a transaction
    bridge_dly = 8;
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    n = 0;
    while (!outstanding && n < 10) begin idle(); n++; end
    check("rst_mid_outstanding", 32'(outstanding), 32'd1);
    idle();
    #2 rstn = 1'b0;
    #1;
    check_all_zero("rst_mid");
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    bridge_dly = 2;
    dc0 = data_resp_cnt;
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    drain("t_after_reset", 50);
    check("t7_data_resp_n", 32'(data_resp_cnt - dc0), 32'd1);
    check("t7_data_resp_data", data_resp_data, bridge_fn(32'h8));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memrq_arbiter.md
Name: memrq_arbiter

Overview:
- Two-client request arbiter that sits directly upstream of the single-port memory request to AXI bridge.
- Merges the instruction-fetch client (read-only) and the data client (read/write) onto one request_enable/req_mode/req_addr/req_wdata/req_wstrb interface.
- Keeps exactly one transaction outstanding downstream and routes each response_enable/resp_data back to the client that issued the request.

Parameters:
- ISSUE_GAP, 0, number of extra idle cycles inserted after a downstream response before the next request may issue (0 to 15).

Ports:
- clk  in  1  clock; all logic on posedge.
- rstn  in  1  asynchronous active-low reset.
- inst_request_enable  in  1  one-cycle pulse; instruction read request.
- inst_req_addr  in  32  instruction read address.
- inst_response_enable  out  1  one-cycle pulse; instruction response valid.
- inst_resp_data  out  32  instruction read data.
- data_request_enable  in  1  one-cycle pulse; data request.
- data_req_mode  in  1  0 = read, 1 = write.
- data_req_addr  in  32  data address.
- data_req_wdata  in  32  write data.
- data_req_wstrb  in  4  byte strobes.
- data_response_enable  out  1  one-cycle pulse; data response valid.
- data_resp_data  out  32  data read data.
- request_enable  out  1  one-cycle pulse to the bridge.
- req_mode  out  1  to the bridge.
- req_addr  out  32  to the bridge.
- req_wdata  out  32  to the bridge.
- req_wstrb  out  4  to the bridge.
- response_enable  in  1  one-cycle pulse from the bridge.
- resp_data  in  32  read data from the bridge.
- busy  out  1  high while a downstream transaction is outstanding.
- overrun  out  1  sticky error flag: a client pulsed while its own request was still pending.

Behaviour:
- Reset (rstn=0, asynchronous): clears every output register, both pending slots, the gap counter and last_grant (last_grant=INST); state=IDLE.
  - Reset mid-transaction abandons the transaction; no response is delivered. The bridge shares rstn and resets together.
- Capture:
  - A client request_enable pulse sampled at an edge loads that client's pending slot at the same edge: valid=1, addr (and mode/wdata/wstrb for data).
  - An instruction request is captured as mode=0, wdata=0, wstrb=0.
  - A pulse while that client's slot is already valid is ignored (the slot is not overwritten) and sets overrun=1 until reset.
- FSM:
  - IDLE: if any slot is valid, pick a winner, drive request_enable=1 with the winner's fields, set owner=winner, go to ISSUE.
  - ISSUE: request_enable<=0, go to WAIT_RESP. request_enable is therefore high for exactly one cycle.
  - WAIT_RESP: on response_enable=1:
    - pulse the owner's *_response_enable for one cycle and load the owner's *_resp_data from resp_data. For writes, data_resp_data takes resp_data as-is.
    - clear the owner's slot, set last_grant=owner.
    - load the gap counter with ISSUE_GAP and go to GAP, or go to IDLE directly if ISSUE_GAP=0.
  - GAP: decrement the counter each cycle; go to IDLE when it reaches 1.
- The non-owner's *_resp_data holds its previous value.
- busy=1 in ISSUE, WAIT_RESP and GAP.
- Latency:
  - Client pulse at edge E0 → request_enable high in the cycle after E1. Minimum 2 edges.
  - Downstream response at edge Er → client response pulse in the cycle after Er, next request_enable at the earliest in the cycle after Er+1+ISSUE_GAP.
  - This respects the bridge's one-cycle return to its request-accepting state.
- Same-edge events:
  - A capture for the non-owner at the response edge is kept.
  - A capture for the owner at the response edge cannot occur under protocol, because the client has not yet seen its response. If it does occur, the clear wins and the pulse counts as an overrun.
- Arbitration (default): fixed priority, data before instruction.
- response_enable while in IDLE, ISSUE or GAP is ignored.

Optional Feature:
- Macro MEMARB_ROUND_ROBIN_EN.
- Defined: when both slots are valid in IDLE, grant the client that is not last_grant. Reset value last_grant=INST, so data wins the first tie.
- Undefined: fixed data-over-instruction priority; last_grant is still maintained but unused.

Test Plan:
- Single instruction read: inst pulse with addr=0x00000100; bridge model returns 0xDEADBEEF 3 cycles after request_enable → one request_enable pulse with req_mode=0, req_addr=0x100; inst_response_enable pulses once; inst_resp_data=0xDEADBEEF; data_response_enable stays 0.
- Data write: data pulse with mode=1, addr=0x80000004, wdata=0x12345678, wstrb=0b0011 → request fields match; data_response_enable pulses once; busy falls the cycle after the response.
- Contention: inst and data pulse on the same edge, addresses 0x10 and 0x20 → default build issues 0x20 then 0x10. With MEMARB_ROUND_ROBIN_EN, repeat with both continuously re-requesting and check grants alternate D, I, D, I.
- Gap: ISSUE_GAP=3, both slots pending → exactly 1+3 idle cycles between the first response_enable and the second request_enable.
- Overrun: second inst pulse (addr 0x40) while the first (0x30) is pending → only 0x30 is issued; overrun=1 and stays 1 until rstn is asserted.
- Reset mid-transaction: assert rstn=0 during WAIT_RESP → all outputs 0 immediately; after release, a new data read to 0x8 completes normally.
